mem_port_arbiter: RTL and testbench

//  Shares one single-port instruction/data RAM between the fetch stage and the memory stage of
//  the 5-stage pipeline. Accepts at most one outstanding access, sequences the fixed-latency RAM,

---
 rtl/rv_pipe_pkg.sv | 11 +
 rtl/arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types for the pipeline memory-port arbiter: FSM state, grant owner, fixed word func3.
package rv_pipe_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DM} grant_t;

  localparam logic [2:0] F3_WORD = 3'b010;
  // Latency counter width; MEM_LAT must fit (1..15)
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between fetch and data requesters.
// ARB_RR_EN selects round-robin on contention; otherwise data always wins.
module arb_pick
  import rv_pipe_pkg::*;
(
  input  logic   if_req,
  input  logic   dm_req,
  input  grant_t last_gnt,
  output grant_t win
);

`ifdef ARB_RR_EN
  always_comb begin
    win = dm_req ? GNT_DM : GNT_IF;
    if (if_req && dm_req) begin
      win = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
    end
  end
`else
  // Fetch wins only by absence of a data request, so if_req/last_gnt carry no information here
  logic unused_pick_in;
  assign unused_pick_in = ^{if_req, last_gnt};
  assign win = dm_req ? GNT_DM : GNT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between fetch and memory stage, one access in flight.
// Optional ARB_RR_EN: round-robin on contention (adds last_gnt register).
module mem_port_arbiter
  import rv_pipe_pkg::*;
#(
  parameter int unsigned WD      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [WD-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [WD-1:0] dm_wdata,
  input  logic [2:0]    dm_func3,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [WD-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  output logic [2:0]    mem_func3,
  input  logic [WD-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  grant_t           owner_q, owner_d;
  logic             store_q, store_d;
  logic [AW-1:0]    addr_q;
  logic [WD-1:0]    wdata_q;
  logic [2:0]       func3_q;

  grant_t pick;
  grant_t last_gnt;
  logic   grant;
  logic   done;

  arb_pick u_pick (
    .if_req   (if_req),
    .dm_req   (dm_req),
    .last_gnt (last_gnt),
    .win      (pick)
  );

  // rst gates the grant so nothing is strobed while reset is held
  assign grant = rst && (state_q == ARB_IDLE) && (if_req || dm_req);
  assign done  = (state_q == ARB_BUSY) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    store_d = store_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d = ARB_BUSY;
          cnt_d   = LAT;
          owner_d = pick;
          store_d = (pick == GNT_DM) && dm_we;
        end
      end
      ARB_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      owner_q <= GNT_IF;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

`ifdef ARB_RR_EN
  grant_t last_gnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= GNT_IF;
    end else if (grant) begin
      last_gnt_q <= pick;
    end
  end

  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = GNT_IF;
`endif

  // RAM address/data follow the winner in the grant cycle and hold afterwards
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_func3 = func3_q;
    if (grant) begin
      if (pick == GNT_DM) begin
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_func3 = dm_func3;
      end else begin
        mem_addr  = if_addr;
        mem_wdata = '0;
        mem_func3 = F3_WORD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
    end else if (grant) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      func3_q <= mem_func3;
    end
  end

  assign mem_en    = grant;
  assign mem_we    = grant && (pick == GNT_DM) && dm_we;
  assign if_gnt    = grant && (pick == GNT_IF);
  assign dm_gnt    = grant && (pick == GNT_DM);
  assign if_rvalid = done && (owner_q == GNT_IF);
  assign dm_rvalid = done && (owner_q == GNT_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid && !store_q) ? mem_rdata : '0;

  assign stall_m = rst && dm_req && !dm_rvalid;
  assign stall_f = rst && ((if_req && !if_rvalid) || stall_m);

  // Requesters must hold req until their rvalid
  a_if_hold : assert property (@(posedge clk) disable iff (!rst)
    (state_q == ARB_BUSY && owner_q == GNT_IF) |-> if_req);
  a_dm_hold : assert property (@(posedge clk) disable iff (!rst)
    (state_q == ARB_BUSY && owner_q == GNT_DM) |-> dm_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2 instance plus a MEM_LAT=1 instance).
module tb_mem_port_arbiter;

`ifdef ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_func3, mem_func3;
  logic        mem_en, mem_we, stall_f, stall_m;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if1_req, if1_gnt, if1_rvalid;
  logic [31:0] if1_addr, if1_rdata;
  logic        dm1_req, dm1_we, dm1_gnt, dm1_rvalid;
  logic [31:0] dm1_addr, dm1_wdata, dm1_rdata;
  logic [2:0]  dm1_func3, mem1_func3;
  logic        mem1_en, mem1_we, stall1_f, stall1_m;
  logic [31:0] mem1_addr, mem1_wdata, mem1_rdata;

  mem_port_arbiter #(.WD(32), .AW(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_func3(dm_func3), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_port_arbiter #(.WD(32), .AW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid),
    .if_rdata(if1_rdata),
    .dm_req(dm1_req), .dm_we(dm1_we), .dm_addr(dm1_addr), .dm_wdata(dm1_wdata),
    .dm_func3(dm1_func3), .dm_gnt(dm1_gnt), .dm_rvalid(dm1_rvalid), .dm_rdata(dm1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_func3(mem1_func3), .mem_rdata(mem1_rdata), .stall_f(stall1_f), .stall_m(stall1_m)
  );

  // RAM model: access sampled mid-cycle; data appears 2 (u_dut) or 1 (u_dut1) cycles later
  logic [31:0] ram [256];
  logic [31:0] p1, p2, q1;
  assign mem_rdata  = p2;
  assign mem1_rdata = q1;

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 4) ? 32'h0050_0093 : (32'hA5A5_0000 | 32'(idx));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    p1 = '0;
    p2 = '0;
    q1 = '0;
    forever begin
      @(negedge clk);
      p2 = p1;
      if (mem_en) begin
        p1 = ram[mem_addr[9:2]];
        if (mem_we) ram[mem_addr[9:2]] = mem_wdata;
      end
      if (mem1_en) q1 = ram[mem1_addr[9:2]];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if_req  = 1'b0;
    dm_req  = 1'b0;
    dm1_req = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int nrv;
  int ng;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_func3 = 3'b010;
    if1_req = 1'b0; if1_addr = '0;
    dm1_req = 1'b0; dm1_we = 1'b0; dm1_addr = '0; dm1_wdata = '0; dm1_func3 = 3'b010;
    cyc();
    #1;
    check("reset_outs", 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we,
                              stall_f, stall_m}), 32'h0);
    check("reset_addr", mem_addr, 32'h0);

    // 1: reset mid-access
    do_reset();
    cyc(); if_req = 1'b1; if_addr = 32'h10; #1;
    check("t1_gnt", 32'(if_gnt), 32'd1);
    cyc(); rst = 1'b0; #1;
    check("t1_rst_outs", 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we,
                               stall_f, stall_m}), 32'h0);
    check("t1_rst_data", if_rdata | mem_addr, 32'h0);
    if_req = 1'b0;
    cyc();
    cyc(); rst = 1'b1;
    nrv = 0;
    repeat (4) begin
      cyc(); #1;
      nrv += int'(if_rvalid);
    end
    check("t1_no_rvalid", 32'(nrv), 32'd0);

    // 2: lone fetch
    cyc(); if_req = 1'b1; if_addr = 32'h10; #1;
    check("t2_gnt", 32'(if_gnt), 32'd1);
    check("t2_en", 32'(mem_en), 32'd1);
    check("t2_addr", mem_addr, 32'h10);
    check("t2_f3", 32'(mem_func3), 32'd2);
    check("t2_we", 32'(mem_we), 32'd0);
    check("t2_stall_t", 32'(stall_f), 32'd1);
    cyc(); if_addr = 32'h44; #1;
    check("t2_stall_t1", 32'(stall_f), 32'd1);
    check("t2_en_off", 32'(mem_en), 32'd0);
    check("t2_addr_hold", mem_addr, 32'h10);
    check("t2_early", 32'(if_rvalid), 32'd0);
    cyc(); #1;
    check("t2_rvalid", 32'(if_rvalid), 32'd1);
    check("t2_rdata", if_rdata, 32'h0050_0093);
    check("t2_stall_t2", 32'(stall_f), 32'd0);
    cyc(); if_req = 1'b0;

    // 3: store then reload
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_func3 = 3'b010;
    #1;
    check("t3_gnt", 32'(dm_gnt), 32'd1);
    check("t3_we", 32'(mem_we), 32'd1);
    check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t3_addr", mem_addr, 32'h100);
    check("t3_stalls", 32'({stall_m, stall_f}), 32'd3);
    cyc();
    cyc(); #1;
    check("t3_rvalid", 32'(dm_rvalid), 32'd1);
    check("t3_rdata0", dm_rdata, 32'h0);
    check("t3_stall_m", 32'(stall_m), 32'd0);
    cyc(); dm_we = 1'b0; dm_wdata = '0; #1;
    check("t3_ld_gnt", 32'(dm_gnt), 32'd1);
    check("t3_ld_we", 32'(mem_we), 32'd0);
    cyc();
    cyc(); #1;
    check("t3_ld_rvalid", 32'(dm_rvalid), 32'd1);
    check("t3_ld_rdata", dm_rdata, 32'hDEAD_BEEF);
    cyc(); dm_req = 1'b0;

    // 4: simultaneous requests
    do_reset();
    cyc(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; #1;
    check("t4_dm_gnt", 32'({dm_gnt, if_gnt}), 32'd2);
    check("t4_addr", mem_addr, 32'h100);
    check("t4_stall_t", 32'(stall_f), 32'd1);
    cyc(); #1;
    check("t4_stall_t1", 32'(stall_f), 32'd1);
    cyc(); #1;
    check("t4_dm_rvalid", 32'(dm_rvalid), 32'd1);
    check("t4_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("t4_stall_t2", 32'({stall_f, stall_m}), 32'd2);
    cyc(); dm_req = 1'b0; #1;
    check("t4_if_gnt", 32'({dm_gnt, if_gnt}), 32'd1);
    check("t4_stall_t3", 32'(stall_f), 32'd1);
    cyc(); #1;
    check("t4_stall_t4", 32'(stall_f), 32'd1);
    cyc(); #1;
    check("t4_if_rvalid", 32'(if_rvalid), 32'd1);
    check("t4_if_rdata", if_rdata, 32'h0050_0093);
    check("t4_stall_t5", 32'(stall_f), 32'd0);
    cyc(); if_req = 1'b0;

    // 5: continuous contention
    do_reset();
    cyc(); if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_addr = 32'h20; dm_func3 = 3'b100;
    ng = 0;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) cyc();
      #1;
      if (if_gnt || dm_gnt) begin
        check("t5_slot", 32'(c), 32'(3 * ng));
        check("t5_side", 32'(dm_gnt), (RrEn && (ng % 2 == 1)) ? 32'd0 : 32'd1);
        check("t5_f3", 32'(mem_func3), dm_gnt ? 32'd4 : 32'd2);
        ng++;
      end
    end
    check("t5_count", 32'(ng), 32'd6);
    cyc(); if_req = 1'b0; dm_req = 1'b0; dm_func3 = 3'b010;

    // 6: MEM_LAT=1 back-to-back loads
    for (int k = 0; k < 3; k++) begin
      cyc(); dm1_req = 1'b1; dm1_addr = 32'(4 * (k + 1)); #1;
      check("t6_gnt", 32'({dm1_gnt, mem1_en, dm1_rvalid}), 32'd6);
      check("t6_stall", 32'({stall1_m, stall1_f}), 32'd3);
      cyc(); #1;
      check("t6_rvalid", 32'({dm1_gnt, dm1_rvalid}), 32'd1);
      check("t6_rdata", dm1_rdata, init_word(k + 1));
      check("t6_stall_off", 32'({stall1_m, stall1_f}), 32'd0);
    end
    check("t6_if_side", 32'({if1_gnt, if1_rvalid, mem1_we}) | if1_rdata | mem1_wdata, 32'd0);
    check("t6_f3", 32'(mem1_func3), 32'd2);
    cyc(); dm1_req = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
